// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid stage.
// The ALU-op field sits in ctrl[4:0]; the bubble carries passb there and zeros elsewhere.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [4:0] ALU_OP_PASSB = 5'b10011;
  localparam int CTRL_W_DEF = 24;
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF = {{(CTRL_W_DEF-5){1'b0}}, ALU_OP_PASSB};

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Ready/valid bundle for pipe_stage_skid: upstream in_* side and downstream out_* side.
// slave is the stage's view; master is the view of whoever surrounds the stage.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = pipe_pkg::CTRL_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_slot_reg.sv
// One payload slot: data+control storage with load and bubble-load.
// A bubble load replaces only the control payload; data keeps its last value.
module pipe_slot_reg #(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load_i,
  input  logic              load_nop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q <= '0;
      ctrl_q <= CTRL_NOP;
    end else if (load_nop_i) begin
      ctrl_q <= CTRL_NOP;
    end else if (load_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with bubble insertion and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a skid slot and registered in_ready; otherwise in_ready is combinational.
// state | meaning
// EMPTY | no entry held
// BUSY  | main slot valid
// FULL  | main and skid slots valid
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF),
  parameter int                CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);
  state_e            state_q, state_d;
  logic              in_ready, out_valid, accept, issue;
  logic              main_load, main_nop;
  logic [DATA_W-1:0] main_din, main_data;
  logic [CTRL_W-1:0] main_cin, main_ctrl;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign issue     = out_valid & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_q, skid_load, skid_nop, main_from_skid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready = in_ready_q;
  assign main_din = main_from_skid ? skid_data : bus.in_data;
  assign main_cin = main_from_skid ? skid_ctrl : bus.in_ctrl;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) in_ready_q <= 1'b1;
    else       in_ready_q <= (state_d != ST_FULL);
  end

  pipe_slot_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_skid (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_i     (skid_load),
    .load_nop_i (skid_nop),
    .data_i     (bus.in_data),
    .ctrl_i     (bus.in_ctrl),
    .data_o     (skid_data),
    .ctrl_o     (skid_ctrl)
  );
`else
  assign in_ready = ~out_valid | bus.out_ready;
  assign main_din = bus.in_data;
  assign main_cin = bus.in_ctrl;
`endif

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_nop  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    skid_nop       = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      state_d  = ST_EMPTY;
      main_nop = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_nop = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_BUSY;
            main_load = 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && issue) begin
            main_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
`endif
          end else if (issue) begin
            state_d  = ST_EMPTY;
            main_nop = 1'b1;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (issue) begin
            state_d        = ST_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  pipe_slot_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_main (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_i     (main_load),
    .load_nop_i (main_nop),
    .data_i     (main_din),
    .ctrl_i     (main_cin),
    .data_o     (main_data),
    .ctrl_o     (main_ctrl)
  );

  // Counts every stalled cycle, including one coinciding with flush
  assign stall_cnt_d = (out_valid && !bus.out_ready && !(&stall_cnt_q)) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_ctrl;
  assign stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, corner sequences and an ordering scoreboard.
module tb_pipe_stage_skid;
  localparam int DW = 128;
  localparam int CW = 24;
  localparam int CNT_W = 16;
  localparam logic [CW-1:0] NOP = 24'h000013;
`ifdef PIPE_STAGE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int exp_stall = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  ent_t sb[$];

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        ordy;
    logic        exp_ov;
    logic        exp_ir;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = {112'h0, d};
    bus.in_ctrl   = {8'h5A, d};
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_hs(input string tag, input logic ov, input logic ir);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(ov));
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(ir));
  endtask

  // Scoreboard and stall model, evaluated mid-cycle for the coming rising edge
  always @(negedge CLK) begin
    if (RESET) begin
      sb.delete();
      exp_stall = 0;
    end else begin
      if (bus.out_valid && !bus.out_ready && exp_stall < 65535) exp_stall++;
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected actual_data=%0h required=none", bus.out_data);
          end else begin
            ent_t e;
            e = sb.pop_front();
            chk("sb_data", bus.out_data, e.d);
            chk("sb_ctrl", 128'(bus.out_ctrl), 128'(e.c));
          end
        end
        if (bus.in_valid && bus.in_ready) sb.push_back('{d: bus.in_data, c: bus.in_ctrl});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #12;
    expect_hs("rst", 1'b0, 1'b1);
    chk("rst_data", bus.out_data, 128'h0);
    chk("rst_ctrl", 128'(bus.out_ctrl), 128'(NOP));
    chk("rst_stall", 128'(stall_cnt), 128'h0);
    #10 RESET = 1'b0;
    nxt();

    // Streaming with gaps, no backpressure while a stage entry is held
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ordy, 1'b0);
      #1;
      expect_hs($sformatf("tbl%0d", i), tbl[i].exp_ov, tbl[i].exp_ir);
      if (!tbl[i].exp_ov) chk($sformatf("tbl%0d_ctrl_nop", i), 128'(bus.out_ctrl), 128'(NOP));
      nxt();
    end

    // Backpressure: A held, B offered; A then B drain in order
    drive(1'b1, 16'h00A0, 1'b0, 1'b0); #1; expect_hs("a0", 1'b0, 1'b1); nxt();
    drive(1'b1, 16'h00B0, 1'b0, 1'b0); #1; expect_hs("a1", 1'b1, SKID);
    chk("a1_data", bus.out_data, 128'h00A0); nxt();
    drive(1'b0, 16'h0, 1'b0, 1'b0); #1; expect_hs("a2", 1'b1, 1'b0);
    chk("a2_data", bus.out_data, 128'h00A0); nxt();
    drive(1'b0, 16'h0, 1'b1, 1'b0); #1; expect_hs("a3", 1'b1, !SKID);
    chk("a3_data", bus.out_data, 128'h00A0); nxt();
    drive(1'b0, 16'h0, 1'b1, 1'b0); #1; expect_hs("a4", SKID, 1'b1);
    chk("a4_data", bus.out_data, SKID ? 128'h00B0 : 128'h00A0); nxt();
    drive(1'b0, 16'h0, 1'b1, 1'b0); #1; expect_hs("a5", 1'b0, 1'b1);
    chk("a5_ctrl_nop", 128'(bus.out_ctrl), 128'(NOP)); nxt();

    // Flush with held entries and an incoming one, then flush from empty
    drive(1'b1, 16'h00C0, 1'b0, 1'b0); #1; expect_hs("f0", 1'b0, 1'b1); nxt();
    drive(1'b1, 16'h00D0, 1'b0, 1'b0); #1; expect_hs("f1", 1'b1, SKID); nxt();
    drive(1'b1, 16'h00E0, 1'b0, 1'b1); #1; expect_hs("f2", 1'b1, 1'b0); nxt();
    drive(1'b0, 16'h0, 1'b1, 1'b0); #1; expect_hs("f3", 1'b0, 1'b1);
    chk("f3_ctrl_nop", 128'(bus.out_ctrl), 128'(NOP));
    chk("f3_data_hold", bus.out_data, 128'h00C0); nxt();
    drive(1'b1, 16'h00F7, 1'b1, 1'b1); #1; expect_hs("f4", 1'b0, 1'b1); nxt();
    drive(1'b1, 16'h00F0, 1'b1, 1'b0); #1; expect_hs("f5", 1'b0, 1'b1); nxt();
    drive(1'b0, 16'h0, 1'b1, 1'b0); #1; expect_hs("f6", 1'b1, 1'b1);
    chk("f6_data", bus.out_data, 128'h00F0); nxt();
    drive(1'b0, 16'h0, 1'b1, 1'b0); #1; expect_hs("f7", 1'b0, 1'b1); nxt();

    // Long stall drives the counter into saturation; flush must not clear it
    drive(1'b1, 16'h0111, 1'b1, 1'b0); #1; nxt();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (10) nxt();
    chk("s_cnt_10", 128'(stall_cnt), 128'(exp_stall));
    repeat (65541) nxt();
    chk("s_cnt_sat", 128'(stall_cnt), 128'hFFFF);
    chk("s_cnt_model", 128'(stall_cnt), 128'(exp_stall));
    flush = 1'b1; nxt();
    flush = 1'b0; #1;
    chk("s_cnt_after_flush", 128'(stall_cnt), 128'hFFFF);
    expect_hs("s_flush", 1'b0, 1'b1);
    nxt();

    // Asynchronous reset mid-stream, then combinational ready tracking
    drive(1'b1, 16'h00D1, 1'b0, 1'b0); #1; nxt();
    drive(1'b0, 16'h0, 1'b0, 1'b0); #1; expect_hs("r0", 1'b1, SKID);
    #1 RESET = 1'b1;
    #1;
    expect_hs("r_async", 1'b0, 1'b1);
    chk("r_async_data", bus.out_data, 128'h0);
    chk("r_async_ctrl", 128'(bus.out_ctrl), 128'(NOP));
    chk("r_async_stall", 128'(stall_cnt), 128'h0);
    #3 RESET = 1'b0;
    nxt();
    drive(1'b1, 16'h00E1, 1'b0, 1'b0); #1; expect_hs("r1", 1'b0, 1'b1); nxt();
    drive(1'b0, 16'h0, 1'b0, 1'b0); #1; expect_hs("r2", 1'b1, SKID);
    bus.out_ready = 1'b1; #1;
    chk("r2_ready_follow", 128'(bus.in_ready), 128'h1);
    chk("r2_data", bus.out_data, 128'h00E1);
    nxt();
    drive(1'b0, 16'h0, 1'b1, 1'b0); #1; expect_hs("r3", 1'b0, 1'b1);
    repeat (3) nxt();
    chk("end_sb_empty", 128'(sb.size()), 128'h0);
    chk("end_stall", 128'(stall_cnt), 128'(exp_stall));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, 128, width of data payload (e.g. PC, PRA, PRB, sign-extended immediate).
REQ-002 SHALL have parameter CTRL_W, 24, width of control payload (e.g. register addresses, FU/ALU ops, write enables).
REQ-003 SHALL have parameter CTRL_NOP, all-zero except ALU-op field = 5'b10011 (passb), the bubble value for control payload.
REQ-004 SHALL have parameter CNT_W, 16, width of the stall counter.
REQ-005 SHALL have port CLK  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port flush  in  1  synchronous kill of all held entries.
REQ-008 SHALL have port in_valid  in  1  upstream entry present.
REQ-009 SHALL have port in_ready  out  1  stage accepts an entry this cycle.
REQ-010 SHALL have port in_data  in  DATA_W  upstream data payload.
REQ-011 SHALL have port in_ctrl  in  CTRL_W  upstream control payload.
REQ-012 SHALL have port out_valid  out  1  output entry present.
REQ-013 SHALL have port out_ready  in  1  downstream accepts.
REQ-014 SHALL have port out_data  out  DATA_W  registered data payload.
REQ-015 SHALL have port out_ctrl  out  CTRL_W  registered control payload; CTRL_NOP whenever out_valid=0.
REQ-016 SHALL have port stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL define accept = in_valid & in_ready and issue = out_valid & out_ready.
REQ-018 SHALL implement states EMPTY (no entry), BUSY (main slot valid), FULL (main and skid valid).
REQ-019 EMPTY: accept -> BUSY, main <= input; out_valid rises next cycle (latency 1).
REQ-020 BUSY: accept & issue -> BUSY, main <= input; accept & !issue -> FULL, skid <= input; !accept & issue -> EMPTY.
REQ-021 FULL: no accept; issue -> BUSY, main <= skid.
REQ-022 SHALL register in_ready, equal to 1 exactly when the next state is not FULL.
REQ-023 SHALL preserve entry order; no entry duplicated or dropped except by flush.
REQ-024 On entering EMPTY, out_ctrl SHALL load CTRL_NOP; out_data SHALL hold its last value.
REQ-025 flush SHALL take priority over all transfers: next state EMPTY, both slots invalidated, out_ctrl <= CTRL_NOP, input present that cycle discarded, in_ready <= 1.
REQ-026 stall_cnt SHALL increment per stall cycle, saturate at all-ones, and not clear on flush.

Reset
REQ-027 While RESET=1: state EMPTY, out_valid 0, out_data 0, out_ctrl CTRL_NOP, skid cleared, in_ready 1, stall_cnt 0.
REQ-028 Reset asserted mid-transfer SHALL discard all held entries without emitting them.

Configuration
REQ-029 With macro PIPE_STAGE_SKID_EN defined, the skid slot and FULL state SHALL exist as above.
REQ-030 Without PIPE_STAGE_SKID_EN: no skid slot, FULL unreachable, in_ready = !out_valid | out_ready (combinational); other behaviour unchanged.

Structure
REQ-031 Package pipe_pkg SHALL hold the state enumeration, the passb opcode constant 5'b10011, and the default CTRL_NOP.
REQ-032 Main and skid slots SHALL each be an instance of sub-module pipe_slot_reg (DATA_W+CTRL_W storage, load enable, load-NOP input).

Verification
REQ-033 Reset release, in_valid=1 data=0x1 continuously, out_ready=1 -> out_valid from cycle 2, one entry per cycle, in order.
REQ-034 BUSY with entry A, out_ready=0, push B -> FULL, in_ready=0 next cycle; out_ready=1 -> A then B on consecutive cycles.
REQ-035 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_NOP, in_ready=1; incoming entry absent from output.
REQ-036 out_ready=0 with out_valid=1 for 2^CNT_W+5 cycles -> stall_cnt saturates at all-ones.
REQ-037 RESET pulse mid-stream between clock edges -> outputs reach reset values immediately; without PIPE_STAGE_SKID_EN, in_ready follows out_ready same cycle.
